// File: rtl/pll_lock_reset_seq.sv
// Purpose : synchronise and qualify raw PLL lock indicators, then release per-domain
//           active-low resets in index order once every lock has been stable long enough.
// Latency : lock_in rise -> all_locked after SYNC_STAGES+1 edges; rst_out_n[0] rises
//           STABLE_CYCLES edges after STABLE entry, each further bit STEP_CYCLES later.
// Backpressure: none; lock loss or force_reset drops every reset together on the next edge.
//
// Ports:
//   clk, rst_n        27 MHz reference clock, asynchronous active-low reset
//   lock_in           raw PLL lock indicators (bit0 core, bit1 hdmi, bit2 audio), async to clk
//   force_reset       level request to hold / restart the sequence
//   clear_sticky      clears lock_lost_sticky (a new lock loss in the same cycle wins)
//   rst_out_n         registered active-low domain resets, released 0..NUM_RESETS-1
//   all_locked        registered AND of the synchronised locks
//   seq_done          high while in RUN (all resets released)
//   lock_lost_sticky  set by a lock loss seen in RELEASE or RUN
//   state_o           FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
module pll_lock_reset_seq #(
    parameter int NUM_LOCKS     = 3,
    parameter int NUM_RESETS    = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2048,
    parameter int STEP_CYCLES   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LOCKS-1:0]  lock_in,
    input  logic                  force_reset,
    input  logic                  clear_sticky,
    output logic [NUM_RESETS-1:0] rst_out_n,
    output logic                  all_locked,
    output logic                  seq_done,
    output logic                  lock_lost_sticky,
    output logic [1:0]            state_o
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int PW = $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [PW-1:0] STEP_LAST   = PW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_LOCKS-1:0]    sync_q [SYNC_STAGES];
    logic                    all_locked_q;
    logic [SW-1:0]           stable_cnt_q, stable_cnt_d;
    logic [PW-1:0]           step_cnt_q, step_cnt_d;
    logic [NUM_RESETS-1:0]   rst_out_n_q, rst_out_n_d;
    logic [NUM_RESETS-1:0]   rst_shift;
    logic                    sticky_q, sticky_d, sticky_set;
    logic                    lock_and;
    logic                    abort;

    // ------------------------------------------------------------------
    // Lock synchroniser; the FSM and the all_locked register share lock_and
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            all_locked_q <= 1'b0;
        end else begin
            sync_q[0] <= lock_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            all_locked_q <= lock_and;
        end
    end

    assign lock_and = &sync_q[SYNC_STAGES-1];
    assign abort    = ~lock_and | force_reset;

    // Next reset pattern: one more low-index bit released. Because bits are only
    // ever released by shifting in ones from bit 0, the order invariant holds.
    always_comb begin
        rst_shift    = '0;
        rst_shift[0] = 1'b1;
        for (int i = 1; i < NUM_RESETS; i++) begin
            rst_shift[i] = rst_out_n_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_and && !force_reset) state_d = STABLE;
            end
            STABLE: begin
                if (abort) begin
                    state_d = WAIT_LOCK;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    // With a single reset the first release completes the sequence
                    state_d = (&rst_shift) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_d = WAIT_LOCK;
                end else if ((step_cnt_q == STEP_LAST) && (&rst_shift)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        step_cnt_d   = step_cnt_q;
        rst_out_n_d  = rst_out_n_q;
        sticky_set   = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                stable_cnt_d = '0;
                step_cnt_d   = '0;
                rst_out_n_d  = '0;
            end
            STABLE: begin
                if (abort) begin
                    stable_cnt_d = '0;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    stable_cnt_d = '0;
                    rst_out_n_d  = rst_shift;
                end else begin
                    stable_cnt_d = stable_cnt_q + SW'(1);
                end
            end
            RELEASE: begin
                if (abort) begin
                    stable_cnt_d = '0;
                    step_cnt_d   = '0;
                    rst_out_n_d  = '0;
                    sticky_set   = ~lock_and;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d  = '0;
                    rst_out_n_d = rst_shift;
                end else begin
                    step_cnt_d = step_cnt_q + PW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    stable_cnt_d = '0;
                    step_cnt_d   = '0;
                    rst_out_n_d  = '0;
                    sticky_set   = ~lock_and;
                end
            end
            default: begin
                stable_cnt_d = '0;
                step_cnt_d   = '0;
                rst_out_n_d  = '0;
            end
        endcase

        // A fresh lock loss outranks a simultaneous clear
        if (sticky_set) begin
            sticky_d = 1'b1;
        end else if (clear_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt_q <= '0;
            step_cnt_q   <= '0;
            rst_out_n_q  <= '0;
            sticky_q     <= 1'b0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            step_cnt_q   <= step_cnt_d;
            rst_out_n_q  <= rst_out_n_d;
            sticky_q     <= sticky_d;
        end
    end

    assign rst_out_n        = rst_out_n_q;
    assign all_locked       = all_locked_q;
    assign seq_done         = (state_q == RUN);
    assign lock_lost_sticky = sticky_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Purpose : directed bench for pll_lock_reset_seq with hand-computed release timing.
// Latency : inputs driven 1 ns after a rising edge, outputs sampled at the same point.
// Backpressure: n/a; every wait is a fixed cycle count, a watchdog bounds the run.
module tb_pll_lock_reset_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] lock_in;
    logic       force_reset;
    logic       clear_sticky;
    logic [2:0] rst_out_n;
    logic       all_locked;
    logic       seq_done;
    logic       lock_lost_sticky;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_reset_seq #(
        .NUM_LOCKS    (3),
        .NUM_RESETS   (3),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(16),
        .STEP_CYCLES  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lock_in         (lock_in),
        .force_reset     (force_reset),
        .clear_sticky    (clear_sticky),
        .rst_out_n       (rst_out_n),
        .all_locked      (all_locked),
        .seq_done        (seq_done),
        .lock_lost_sticky(lock_lost_sticky),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Locks just driven all-high with the synchroniser holding zeros:
    // two edges to reach the last stage, STABLE entered on the third.
    task automatic to_stable(input string tag);
        tick(2);
        chk({tag, "/pre_state"}, state_o, 2'd0);
        chk({tag, "/pre_all_locked"}, all_locked, 1'b0);
        tick(1);
        chk({tag, "/stable_state"}, state_o, 2'd1);
        chk({tag, "/all_locked"}, all_locked, 1'b1);
        chk({tag, "/stable_rst"}, rst_out_n, 3'b000);
    endtask

    // From the STABLE entry edge: bit0 at +16, bit1 at +24
    task automatic release_to_011(input string tag);
        tick(15);
        chk({tag, "/rst_pre0"}, rst_out_n, 3'b000);
        chk({tag, "/state_pre0"}, state_o, 2'd1);
        tick(1);
        chk({tag, "/rst_001"}, rst_out_n, 3'b001);
        chk({tag, "/state_rel"}, state_o, 2'd2);
        chk({tag, "/seq_done_rel"}, seq_done, 1'b0);
        tick(7);
        chk({tag, "/rst_pre1"}, rst_out_n, 3'b001);
        tick(1);
        chk({tag, "/rst_011"}, rst_out_n, 3'b011);
        chk({tag, "/state_011"}, state_o, 2'd2);
    endtask

    // From the bit1 release: bit2 and RUN 8 edges later
    task automatic finish_run(input string tag);
        tick(7);
        chk({tag, "/rst_pre2"}, rst_out_n, 3'b011);
        chk({tag, "/seq_done_pre"}, seq_done, 1'b0);
        tick(1);
        chk({tag, "/rst_111"}, rst_out_n, 3'b111);
        chk({tag, "/state_run"}, state_o, 2'd3);
        chk({tag, "/seq_done"}, seq_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] st_or;
        logic [2:0] rst_or;

        rst_n        = 1'b0;
        lock_in      = 3'b111;
        force_reset  = 1'b0;
        clear_sticky = 1'b0;
        #2;
        chk("reset/rst_out_n", rst_out_n, 3'b000);
        chk("reset/all_locked", all_locked, 1'b0);
        chk("reset/seq_done", seq_done, 1'b0);
        chk("reset/sticky", lock_lost_sticky, 1'b0);
        chk("reset/state", state_o, 2'd0);

        // Basic sequence with locks already high at reset release
        tick(2);
        rst_n = 1'b1;
        to_stable("basic");
        release_to_011("basic");
        finish_run("basic");
        chk("basic/sticky", lock_lost_sticky, 1'b0);

        // Lock loss in RUN: audio lock low for 5 edges
        lock_in = 3'b011;
        tick(2);
        chk("runloss/rst_hold", rst_out_n, 3'b111);
        tick(1);
        chk("runloss/rst", rst_out_n, 3'b000);
        chk("runloss/state", state_o, 2'd0);
        chk("runloss/sticky", lock_lost_sticky, 1'b1);
        chk("runloss/seq_done", seq_done, 1'b0);
        tick(2);
        lock_in = 3'b111;
        to_stable("relock");
        release_to_011("relock");
        finish_run("relock");
        chk("relock/sticky_kept", lock_lost_sticky, 1'b1);
        clear_sticky = 1'b1;
        tick(1);
        clear_sticky = 1'b0;
        chk("clear/sticky", lock_lost_sticky, 1'b0);

        // force_reset pulse from RUN restarts without touching sticky
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("frun/rst", rst_out_n, 3'b000);
        chk("frun/state", state_o, 2'd0);
        tick(1);
        chk("frun/restable", state_o, 2'd1);
        release_to_011("frun");
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("frel/rst", rst_out_n, 3'b000);
        chk("frel/state", state_o, 2'd0);
        chk("frel/sticky", lock_lost_sticky, 1'b0);
        tick(1);
        chk("frel/restable", state_o, 2'd1);
        release_to_011("frel");
        finish_run("frel");

        // force_reset held: FSM must not leave WAIT_LOCK
        force_reset = 1'b1;
        st_or  = '0;
        rst_or = '0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            st_or  = st_or | state_o;
            rst_or = rst_or | rst_out_n;
        end
        chk("fhold/state", st_or, 2'd0);
        chk("fhold/rst", rst_or, 3'b000);
        force_reset = 1'b0;
        tick(1);
        chk("fhold/restable", state_o, 2'd1);

        // hdmi lock glitch at cycle 10 of STABLE: no release, full restart
        tick(10);
        chk("sglitch/state10", state_o, 2'd1);
        lock_in = 3'b101;
        tick(3);
        chk("sglitch/state", state_o, 2'd0);
        chk("sglitch/rst", rst_out_n, 3'b000);
        chk("sglitch/sticky", lock_lost_sticky, 1'b0);
        lock_in = 3'b111;
        to_stable("sglitch");
        release_to_011("sglitch");
        finish_run("sglitch");

        // Locks arriving one by one after a reset
        rst_n   = 1'b0;
        lock_in = 3'b000;
        tick(2);
        rst_n   = 1'b1;
        lock_in = 3'b001;
        tick(10);
        lock_in = 3'b101;
        tick(20);
        chk("stagger/state", state_o, 2'd0);
        chk("stagger/all_locked", all_locked, 1'b0);
        lock_in = 3'b111;
        to_stable("stagger");
        release_to_011("stagger");

        // Asynchronous reset mid-RELEASE
        rst_n = 1'b0;
        #1;
        chk("arst/rst", rst_out_n, 3'b000);
        chk("arst/state", state_o, 2'd0);
        chk("arst/all_locked", all_locked, 1'b0);
        chk("arst/seq_done", seq_done, 1'b0);
        chk("arst/sticky", lock_lost_sticky, 1'b0);
        tick(2);
        rst_n = 1'b1;
        to_stable("arst");
        release_to_011("arst");
        finish_run("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
